ysyx_24100005_register_file: RTL and testbench

YSYX_24100005_REGISTER_FILE -- requirements
Module: ysyx_24100005_register_file

---
 rtl/ysyx_24100005_register_file_pkg.sv | 9 +
 rtl/ysyx_24100005_register_file_if.sv | 29 ++
 rtl/ysyx_24100005_reg.sv | 23 ++
 rtl/ysyx_24100005_register_file.sv | 43 ++++
 tb/tb_ysyx_24100005_register_file.sv | 136 +++++++++++++
 5 files changed

// File: rtl/ysyx_24100005_register_file_pkg.sv
`timescale 1ns/1ps
// Shared constants for the register file slice: default geometry and the hardwired zero index.
package ysyx_24100005_register_file_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ZERO_REG       = 0;

endpackage

// File: rtl/ysyx_24100005_register_file_if.sv
`timescale 1ns/1ps
// Write port plus two read ports of the register file.
// The master drives addresses and write data. The slave returns the read data.
interface ysyx_24100005_register_file_if
  import ysyx_24100005_register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata2;

  modport master (
    output wen, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  wen, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/ysyx_24100005_reg.sv
`timescale 1ns/1ps
// Single storage entry: the enable loads the register on the clock edge.
// An asynchronous active-low reset forces RESET_VAL and takes priority over the enable.
module ysyx_24100005_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= RESET_VAL;
    end else if (wen == 1'b1) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_24100005_register_file.sv
`timescale 1ns/1ps
// The register file has 2**ADDR_WIDTH entries, one write port and two read ports. Entry 0 always reads zero.
// Reads are combinational with zero latency and no bypass from the write port. Writes take effect on the clock edge.
module ysyx_24100005_register_file
  import ysyx_24100005_register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_24100005_register_file_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Entry 0 has no storage; this keeps it at zero through writes and through reset.
  assign regs[ZERO_REG] = '0;

  for (genvar i = ZERO_REG + 1; i < DEPTH; i++) begin : g_entry
    logic we;

    // A write happens only when wen is exactly 1. An unknown wen value never counts as a write.
    assign we = (bus.wen == 1'b1) && (bus.waddr == ADDR_WIDTH'(i));

    ysyx_24100005_reg #(
      .WIDTH     (DATA_WIDTH),
      .RESET_VAL ({DATA_WIDTH{1'b0}})
    ) u_reg (
      .clk  (clk),
      .rst  (rst),
      .wen  (we),
      .din  (bus.wdata),
      .dout (regs[i])
    );
  end

  assign bus.rdata1 = regs[bus.raddr1];
  assign bus.rdata2 = regs[bus.raddr2];

endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
`timescale 1ns/1ps
// Directed vector bench for the register file.
// It covers reset, write and read, the zero register, the same-cycle hazard and a full sweep.
module tb_ysyx_24100005_register_file;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ysyx_24100005_register_file_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  ysyx_24100005_register_file #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.wen    = w;
    bus.waddr  = wa;
    bus.wdata  = wd;
    bus.raddr1 = r1;
    bus.raddr2 = r2;
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b1, 5'd5,  32'h8000_0004, 5'd5,  5'd0,  32'h8000_0004, 32'h0000_0000};
    vecs[1] = '{1'b0, 5'd5,  32'h1234_5678, 5'd5,  5'd5,  32'h8000_0004, 32'h8000_0004};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd5,  32'hA5A5_A5A5, 32'h8000_0004};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd31, 32'h0000_0001, 32'hA5A5_A5A5};
    vecs[5] = '{1'b0, 5'd1,  32'h0000_FFFF, 5'd1,  5'd0,  32'h0000_0001, 32'h0000_0000};

    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd31);

    // The design starts in reset, and a write is attempted during reset.
    @(posedge clk); #1;
    check("reset_rd1_x5", bus.rdata1, 32'h0);
    check("reset_rd2_x31", bus.rdata2, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    check("reset_write_suppressed_x5", bus.rdata1, 32'h0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].wen, vecs[k].waddr, vecs[k].wdata, vecs[k].raddr1, vecs[k].raddr2);
      @(posedge clk); #1;
      check($sformatf("vec%0d_rd1", k), bus.rdata1, vecs[k].exp1);
      check($sformatf("vec%0d_rd2", k), bus.rdata2, vecs[k].exp2);
    end

    // Same-cycle hazard: the read returns the old value until the edge.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h1111_1111, 5'd7, 5'd7);
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7);
    #1;
    check("hazard_pre_edge", bus.rdata1, 32'h1111_1111);
    @(posedge clk); #1;
    check("hazard_post_edge", bus.rdata1, 32'h2222_2222);

    // Full sweep over x1..x31.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      bus.raddr1 = 5'(i);
      bus.raddr2 = 5'(32 - i);
      #1;
      check($sformatf("sweep_rd1_x%0d", i), bus.rdata1, 32'(i) * 32'h0101_0101);
      check($sformatf("sweep_rd2_x%0d", 32 - i), bus.rdata2, 32'(32 - i) * 32'h0101_0101);
    end
    bus.raddr1 = 5'd31;
    bus.raddr2 = 5'd31;
    #1;
    check("same_idx31_rd1", bus.rdata1, 32'h1F1F_1F1F);
    check("same_idx31_rd2", bus.rdata2, 32'h1F1F_1F1F);

    // Reset asserted mid-cycle clears the entries at once, without waiting for a clock edge.
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_reset_x31", bus.rdata1, 32'h0);
    bus.raddr2 = 5'd5;
    #1;
    check("async_reset_x5", bus.rdata2, 32'h0);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_x5", bus.rdata1, 32'h0);

    // The first edge after reset is released accepts the write.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'h0000_0055, 5'd5, 5'd4);
    #1;
    check("post_reset_pre_edge", bus.rdata1, 32'h0);
    @(posedge clk); #1;
    check("post_reset_first_write", bus.rdata1, 32'h0000_0055);
    check("post_reset_other_entry", bus.rdata2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
